// File: rtl/rt_obi_section_loader.sv
`default_nettype none
// ============================================================================
// Module      : rt_obi_section_loader
// Description : Streams ELF section payloads into memory over an OBI master
//               port. Accepts (base, byte length) descriptors and a payload
//               word stream, issues auto-incrementing word writes with a
//               partial byte-enable on the tail word, and reports per-section
//               completion, word count and a sticky error flag.
// Options     : RT_LOADER_READBACK_EN - read back and compare every written
//               word before moving on to the next one.
// Revision    : 1.0 - initial release
// ============================================================================
module rt_obi_section_loader #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int LenWidth  = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // section descriptor
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [AddrWidth-1:0]   desc_addr_i,
  input  logic [LenWidth-1:0]    desc_len_i,
  // payload stream
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [DataWidth-1:0]   data_i,
  // OBI master
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  // status
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [LenWidth-1:0]    words_o
);

  localparam int WordBytes = DataWidth / 8;
  localparam int OffW      = (WordBytes > 1) ? $clog2(WordBytes) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WREQ  = 3'd2,
    S_WRSP  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_VREQ  = 3'd6,
    S_VRSP  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]  r_words_left;
  logic [OffW-1:0]      r_tail;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_err;
  logic [LenWidth-1:0]  r_words;
  logic                 r_armed;

  // descriptor decode
  logic [LenWidth:0]    w_words_ceil;
  logic [OffW-1:0]      w_tail;
  logic                 w_unaligned;
  // current word
  logic                 w_last;
  logic [WordBytes-1:0] w_tail_be;
  logic [WordBytes-1:0] w_wr_be;
  // FSM strobes towards the datapath
  logic                 w_ld_desc;
  logic                 w_ld_word;
  logic                 w_wr_ok;
  logic                 w_adv;
  logic                 w_fail;
  logic                 w_drop;
  // registered-path outputs produced by the FSM
  logic                 w_desc_ready;
  logic                 w_data_ready;
  logic                 w_req;
  logic                 w_we;
  logic [WordBytes-1:0] w_be;

  assign w_words_ceil = ({1'b0, desc_len_i} + (LenWidth+1)'(WordBytes - 1)) / (LenWidth+1)'(WordBytes);
  assign w_tail       = OffW'(desc_len_i % LenWidth'(WordBytes));
  assign w_unaligned  = (desc_addr_i % AddrWidth'(WordBytes)) != '0;

  assign w_last    = (r_words_left == LenWidth'(1));
  assign w_tail_be = (WordBytes'(1) << r_tail) - WordBytes'(1);
  assign w_wr_be   = (w_last && (r_tail != '0)) ? w_tail_be : '1;

`ifdef RT_LOADER_READBACK_EN
  logic [DataWidth-1:0] w_bit_mask;
  logic                 w_rb_mismatch;

  for (genvar gi = 0; gi < WordBytes; gi++) begin : g_mask
    assign w_bit_mask[gi*8 +: 8] = {8{w_wr_be[gi]}};
  end

  // only bytes that were actually written take part in the compare
  assign w_rb_mismatch = ((obi_rdata_i ^ r_wdata) & w_bit_mask) != '0;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^obi_rdata_i;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode and per-state outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_desc_ready = 1'b0;
    w_data_ready = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_be         = '0;
    w_ld_desc    = 1'b0;
    w_ld_word    = 1'b0;
    w_wr_ok      = 1'b0;
    w_adv        = 1'b0;
    w_fail       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_desc_ready = r_armed;
        if (desc_valid_i && r_armed) begin
          w_ld_desc = 1'b1;
          if (desc_len_i == '0) begin
            w_state_nxt = S_DONE;
          end else if (w_unaligned) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_data_ready = 1'b1;
        if (data_valid_i) begin
          w_ld_word   = 1'b1;
          w_state_nxt = S_WREQ;
        end
      end
      S_WREQ: begin
        w_req = 1'b1;
        w_we  = 1'b1;
        w_be  = w_wr_be;
        if (obi_gnt_i) begin
          w_state_nxt = S_WRSP;
        end
      end
      S_WRSP: begin
        if (obi_rvalid_i) begin
          if (obi_err_i) begin
            w_fail      = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_DRAIN;
          end else begin
            w_wr_ok = 1'b1;
`ifdef RT_LOADER_READBACK_EN
            w_state_nxt = S_VREQ;
`else
            w_adv       = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_FETCH;
`endif
          end
        end
      end
`ifdef RT_LOADER_READBACK_EN
      S_VREQ: begin
        w_req = 1'b1;
        w_be  = '1;
        if (obi_gnt_i) begin
          w_state_nxt = S_VRSP;
        end
      end
      S_VRSP: begin
        if (obi_rvalid_i) begin
          if (obi_err_i || w_rb_mismatch) begin
            w_fail      = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_DRAIN;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_FETCH;
          end
        end
      end
`endif
      S_DRAIN: begin
        w_data_ready = 1'b1;
        if (r_words_left == '0) begin
          w_state_nxt = S_DONE;
        end else if (data_valid_i) begin
          w_drop = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // keeps the descriptor port closed until the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // section datapath: address, remaining words, tail, payload, status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_words_left <= '0;
      r_tail       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_words      <= '0;
    end else begin
      if (w_ld_desc) begin
        r_addr       <= desc_addr_i;
        r_words_left <= w_words_ceil[LenWidth-1:0];
        r_tail       <= w_tail;
        r_err        <= w_unaligned;
        r_words      <= '0;
      end
      if (w_ld_word) begin
        r_wdata <= data_i;
      end
      if (w_wr_ok) begin
        r_words <= r_words + LenWidth'(1);
      end
      if (w_adv) begin
        r_addr       <= r_addr + AddrWidth'(WordBytes);
        r_words_left <= r_words_left - LenWidth'(1);
      end
      if (w_fail || w_drop) begin
        r_words_left <= r_words_left - LenWidth'(1);
      end
      if (w_fail) begin
        r_err <= 1'b1;
      end
    end
  end

  assign desc_ready_o = w_desc_ready;
  assign data_ready_o = w_data_ready;
  assign obi_req_o    = w_req;
  assign obi_we_o     = w_we;
  assign obi_be_o     = w_be;
  assign obi_addr_o   = r_addr;
  assign obi_wdata_o  = r_wdata;
  assign busy_o       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;
  assign words_o      = r_words;

endmodule
`default_nettype wire

// File: tb/tb_rt_obi_section_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rt_obi_section_loader
// Description : Scoreboard bench for rt_obi_section_loader. The stimulus
//               process queues expected OBI writes and section completions;
//               a monitor pops and compares them as the DUT presents them.
//               An OBI slave model grants, stalls and injects errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rt_obi_section_loader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        desc_valid_i = 1'b0;
  logic        desc_ready_o;
  logic [31:0] desc_addr_i = '0;
  logic [23:0] desc_len_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_i = '0;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;
  logic        obi_err_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [23:0] words_o;

  rt_obi_section_loader #(.AddrWidth(32), .DataWidth(32), .LenWidth(24)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_addr_i(desc_addr_i), .desc_len_i(desc_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [3:0] be; logic [31:0] data;} wr_t;
  typedef struct packed {logic [23:0] words; logic err;} dn_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];

  int n_vec  = 0;
  int n_fail = 0;

  // slave knobs, written by the stimulus process only
  int stall_idx   = -1;
  int stall_n     = 0;
  int err_idx     = -1;
  int corrupt_idx = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- OBI slave model ----------------
  logic [31:0] mem [logic [31:0]];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          stall_cnt = 0;
  logic        rsp_pend = 1'b0;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      rsp_pend     = 1'b0;
      stall_cnt    = 0;
    end else begin
      if (desc_valid_i && desc_ready_o) begin
        wr_idx    = 0;
        rd_idx    = 0;
        stall_cnt = 0;
      end
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      obi_gnt_i    = 1'b0;
      if (rsp_pend) begin
        obi_rvalid_i = 1'b1;
        obi_err_i    = rsp_err;
        obi_rdata_i  = rsp_data;
        rsp_pend     = 1'b0;
      end
      if (obi_req_o) begin
        if (obi_we_o && wr_idx == stall_idx && stall_cnt < stall_n) begin
          stall_cnt++;
        end else begin
          obi_gnt_i = 1'b1;
          rsp_pend  = 1'b1;
          rsp_err   = 1'b0;
          rsp_data  = '0;
          if (obi_we_o) begin
            rsp_err = (wr_idx == err_idx);
            mem[obi_addr_o] = obi_wdata_o;
            wr_idx++;
          end else begin
            rsp_data = mem.exists(obi_addr_o) ? mem[obi_addr_o] : 32'h0;
            if (rd_idx == corrupt_idx) rsp_data = rsp_data ^ 32'h0000_0100;
            rd_idx++;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  wr_t         mon_e;
  dn_t         mon_d;
  logic        stall_act = 1'b0;
  logic [31:0] st_addr, st_data, last_wr_addr;
  logic [3:0]  st_be;

  always @(negedge clk) begin
    #1;
    if (!rst_ni) begin
      stall_act = 1'b0;
    end else begin
      if (obi_req_o && !obi_gnt_i) begin
        if (!stall_act) begin
          stall_act = 1'b1;
          st_addr = obi_addr_o; st_be = obi_be_o; st_data = obi_wdata_o;
        end else begin
          chk("stall_addr_stable", obi_addr_o, st_addr);
          chk("stall_be_stable", obi_be_o, st_be);
          chk("stall_wdata_stable", obi_wdata_o, st_data);
          chk("stall_data_ready_low", data_ready_o, 1'b0);
        end
      end
      if (obi_req_o && obi_gnt_i) begin
        stall_act = 1'b0;
        if (obi_we_o) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write_addr", obi_addr_o, 64'hDEAD_0000_0000);
          end else begin
            mon_e = exp_wr.pop_front();
            chk("wr_addr", obi_addr_o, mon_e.addr);
            chk("wr_be", obi_be_o, mon_e.be);
            chk("wr_data", obi_wdata_o, mon_e.data);
          end
          last_wr_addr = obi_addr_o;
        end else begin
`ifdef RT_LOADER_READBACK_EN
          chk("rd_addr", obi_addr_o, last_wr_addr);
          chk("rd_be", obi_be_o, 4'hF);
`else
          chk("unexpected_read_we", obi_we_o, 1'b1);
`endif
        end
      end
      if (done_o) begin
        chk("done_busy_low", busy_o, 1'b0);
        if (exp_dn.size() == 0) begin
          chk("unexpected_done", done_o, 1'b0);
        end else begin
          mon_d = exp_dn.pop_front();
          chk("done_words", words_o, mon_d.words);
          chk("done_err", err_o, mon_d.err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.be = b; e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_dn(input logic [23:0] w, input logic e);
    dn_t d;
    d.words = w; d.err = e;
    exp_dn.push_back(d);
  endtask

  // returns one step after the accepting clock edge
  task automatic send_desc(input logic [31:0] a, input logic [23:0] l);
    int   n = 0;
    logic ok = 1'b0;
    desc_valid_i = 1'b1; desc_addr_i = a; desc_len_i = l;
    do begin @(negedge clk); ok = desc_ready_o; n++; end while (!ok && n < 300);
    chk("desc_handshake", ok, 1'b1);
    tick();
    desc_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int   n = 0;
    logic ok = 1'b0;
    data_valid_i = 1'b1; data_i = d;
    do begin @(negedge clk); ok = data_ready_o; n++; end while (!ok && n < 300);
    chk("data_handshake", ok, 1'b1);
    tick();
    data_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_dn.size() != 0 && n < 500) begin @(posedge clk); n++; end
    chk("done_seen", exp_dn.size() == 0, 1'b1);
    chk("writes_outstanding", exp_wr.size(), 0);
    tick();
  endtask

  initial begin
    // reset state, sampled while reset is held
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_words", words_o, 24'd0);
    chk("rst_desc_ready", desc_ready_o, 1'b0);
    chk("rst_data_ready", data_ready_o, 1'b0);
    chk("rst_req", obi_req_o, 1'b0);
    rst_ni = 1'b1;
    tick(); tick();

    // basic 4-word section
    push_wr(32'h1000, 4'hF, 32'h1111_1111);
    push_wr(32'h1004, 4'hF, 32'h2222_2222);
    push_wr(32'h1008, 4'hF, 32'h3333_3333);
    push_wr(32'h100C, 4'hF, 32'h4444_4444);
    push_dn(24'd4, 1'b0);
    send_desc(32'h1000, 24'd16);
    chk("accept_to_data_ready", data_ready_o, 1'b1);
    chk("busy_in_section", busy_o, 1'b1);
    send_word(32'h1111_1111);
    chk("data_to_req", obi_req_o, 1'b1);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h4444_4444);
    wait_done();

    // partial tail word: 6 bytes -> be 0x3 on second word
    push_wr(32'h2000, 4'hF, 32'hA1A2_A3A4);
    push_wr(32'h2004, 4'h3, 32'hB5B6_B7B8);
    push_dn(24'd2, 1'b0);
    send_desc(32'h2000, 24'd6);
    send_word(32'hA1A2_A3A4);
    send_word(32'hB5B6_B7B8);
    wait_done();

    // zero length: done on the cycle after accept, no traffic
    push_dn(24'd0, 1'b0);
    send_desc(32'h3000, 24'd0);
    chk("len0_done_next", done_o, 1'b1);
    chk("len0_data_ready", data_ready_o, 1'b0);
    wait_done();
    chk("len0_done_single", done_o, 1'b0);

    // 5-cycle grant stall on the second word
    stall_idx = 1; stall_n = 5;
    push_wr(32'h4000, 4'hF, 32'hC0C0_C0C0);
    push_wr(32'h4004, 4'hF, 32'hC1C1_C1C1);
    push_wr(32'h4008, 4'hF, 32'hC2C2_C2C2);
    push_dn(24'd3, 1'b0);
    send_desc(32'h4000, 24'd12);
    send_word(32'hC0C0_C0C0);
    send_word(32'hC1C1_C1C1);
    send_word(32'hC2C2_C2C2);
    wait_done();
    stall_idx = -1; stall_n = 0;

    // bus error on word 2 of 8: remaining 6 drained
    err_idx = 1;
    push_wr(32'h5000, 4'hF, 32'h5000_0000);
    push_wr(32'h5004, 4'hF, 32'h5000_0001);
    push_dn(24'd1, 1'b1);
    send_desc(32'h5000, 24'd32);
    for (int i = 0; i < 8; i++) send_word(32'h5000_0000 + i);
    wait_done();
    err_idx = -1;
    chk("err_sticky", err_o, 1'b1);

    // unaligned base: error, 2 words drained, no bus traffic
    push_dn(24'd0, 1'b1);
    send_desc(32'h1002, 24'd8);
    chk("unaligned_err", err_o, 1'b1);
    send_word(32'hEEEE_0000);
    send_word(32'hEEEE_0001);
    wait_done();

    // address wrap; accepting this descriptor clears the sticky error
    push_wr(32'hFFFF_FFFC, 4'hF, 32'hD0D0_D0D0);
    push_wr(32'h0000_0000, 4'hF, 32'hD1D1_D1D1);
    push_dn(24'd2, 1'b0);
    send_desc(32'hFFFF_FFFC, 24'd8);
    chk("err_cleared_on_accept", err_o, 1'b0);
    send_word(32'hD0D0_D0D0);
    send_word(32'hD1D1_D1D1);
    wait_done();

`ifdef RT_LOADER_READBACK_EN
    // corrupted readback on the first word
    corrupt_idx = 0;
    push_wr(32'h8000, 4'hF, 32'hE0E0_E0E0);
    push_dn(24'd1, 1'b1);
    send_desc(32'h8000, 24'd12);
    send_word(32'hE0E0_E0E0);
    send_word(32'hE1E1_E1E1);
    send_word(32'hE2E2_E2E2);
    wait_done();
    corrupt_idx = -1;
`endif

    // asynchronous reset in the middle of a section
    push_wr(32'h6000, 4'hF, 32'h6666_0000);
    push_wr(32'h6004, 4'hF, 32'h6666_0001);
    push_wr(32'h6008, 4'hF, 32'h6666_0002);
    push_wr(32'h600C, 4'hF, 32'h6666_0003);
    push_dn(24'd4, 1'b0);
    send_desc(32'h6000, 24'd16);
    send_word(32'h6666_0000);
`ifdef RT_LOADER_READBACK_EN
    tick(); tick(); tick(); tick();
`else
    tick(); tick();
`endif
    chk("pre_rst_words", words_o, 24'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_words", words_o, 24'd0);
    chk("arst_data_ready", data_ready_o, 1'b0);
    chk("arst_desc_ready", desc_ready_o, 1'b0);
    chk("arst_req", obi_req_o, 1'b0);
    chk("arst_addr", obi_addr_o, 32'h0);
    chk("arst_done", done_o, 1'b0);
    exp_wr.delete();
    exp_dn.delete();
    tick(); tick();
    rst_ni = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_no_done", done_o, 1'b0);

    // recovery section
    push_wr(32'h7000, 4'hF, 32'hDEAD_BEEF);
    push_dn(24'd1, 1'b0);
    send_desc(32'h7000, 24'd4);
    send_word(32'hDEAD_BEEF);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire
